// File: rtl/viexo_video_pkg.sv
// viexo_video_pkg: shared types, 640x480@60 timing defaults and helpers for the viexo video timing block
package viexo_video_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef logic [11:0] cnt_t;

  localparam int TMDS_SYMBOL_CLKS = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FRONT_DEF  = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BACK_DEF   = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FRONT_DEF  = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BACK_DEF   = 33;
  localparam bit HSYNC_POL_DEF = 1'b0;
  localparam bit VSYNC_POL_DEF = 1'b0;

  // Line level for a sync signal given whether it is asserted and its asserted polarity.
  function automatic logic sync_level(input logic asserted, input logic pol);
    return asserted ? pol : ~pol;
  endfunction

endpackage

// File: rtl/viexo_symbol_strobe.sv
// viexo_symbol_strobe: mod-10 phase counter aligned to the TMDS lanes' load phase, strobes on phase 9
module viexo_symbol_strobe
  import viexo_video_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  output logic sym_stb_o
);

  localparam logic [3:0] PH_LAST = 4'(TMDS_SYMBOL_CLKS - 1);

  logic [3:0] phase_q, phase_d;

  assign sym_stb_o = phase_q == PH_LAST;

  // Free-running phase, wraps 9 -> 0.
  always_comb phase_d = sym_stb_o ? 4'd0 : phase_q + 4'd1;

  // Phase register, zero from reset so phase 0 matches lane one-hot bit 0.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) phase_q <= 4'd0;
    else         phase_q <= phase_d;

endmodule

// File: rtl/viexo_video_timing.sv
// viexo_video_timing: raster timing and pixel scheduling for three TMDS lanes, one symbol per 10 bit clocks
module viexo_video_timing
  import viexo_video_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit HSYNC_POL = HSYNC_POL_DEF,
  parameter bit VSYNC_POL = VSYNC_POL_DEF
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [23:0] s_pixel_tdata,
  input  logic        s_pixel_tvalid,
  output logic        s_pixel_tready,
  input  logic        underflow_clr,
  output logic        de,
  output logic [1:0]  c_b,
  output logic [7:0]  d_r,
  output logic [7:0]  d_g,
  output logic [7:0]  d_b,
  output logic        frame_start,
  output logic        underflow
);

  localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG  = cnt_t'(H_ACTIVE + H_FRONT);
  localparam cnt_t HS_END  = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam cnt_t VS_BEG  = cnt_t'(V_ACTIVE + V_FRONT);
  localparam cnt_t VS_END  = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam cnt_t H_LAST  = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [1:0] CB_IDLE = {~VSYNC_POL, ~HSYNC_POL};

  state_e     state_q, state_d;
  cnt_t       h_q, h_d, v_q, v_d;
  logic       de_q, de_d;
  logic [1:0] cb_q, cb_d;
  pixel_t     pix_q, pix_d;
  logic       fs_q, fs_d;
  logic       uf_q, uf_d;
  logic       sym_stb, issue, active, hs_act, vs_act, at_origin, h_last, v_last, take;

  viexo_symbol_strobe u_stb (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .sym_stb_o (sym_stb)
  );

  // Decode the pending symbol (h_q, v_q) and compute next state for every register.
  always_comb begin
    at_origin = h_q == '0 && v_q == '0;
    issue     = sym_stb && (state_q == IDLE ? enable : (enable || !at_origin));
    active    = h_q < H_ACT && v_q < V_ACT;
    hs_act    = h_q >= HS_BEG && h_q < HS_END;
    vs_act    = v_q >= VS_BEG && v_q < VS_END;
    h_last    = h_q == H_LAST;
    v_last    = v_q == V_LAST;
    take      = issue && active;
    state_d   = sym_stb ? (issue ? RUN : IDLE) : state_q;
    h_d       = issue ? (h_last ? '0 : h_q + cnt_t'(1)) : h_q;
    v_d       = (issue && h_last) ? (v_last ? '0 : v_q + cnt_t'(1)) : v_q;
    de_d      = sym_stb ? take : de_q;
    cb_d      = sym_stb ? (issue ? {sync_level(vs_act, VSYNC_POL), sync_level(hs_act, HSYNC_POL)} : CB_IDLE) : cb_q;
    pix_d     = sym_stb ? ((take && s_pixel_tvalid) ? pixel_t'(s_pixel_tdata) : '0) : pix_q;
    fs_d      = issue && at_origin;
    uf_d      = (take && !s_pixel_tvalid) || (uf_q && !underflow_clr);
  end

  // Accept strobe is live only during the phase-9 clock of an active symbol, so the
  // pixel is captured on the same edge that loads it into the lanes.
  assign s_pixel_tready = take;

  // FSM, raster counters and registered lane outputs.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      de_q    <= 1'b0;
      cb_q    <= CB_IDLE;
      pix_q   <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      de_q    <= de_d;
      cb_q    <= cb_d;
      pix_q   <= pix_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end

  assign de          = de_q;
  assign c_b         = cb_q;
  assign d_r         = pix_q.r;
  assign d_g         = pix_q.g;
  assign d_b         = pix_q.b;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule
